// File: rtl/blob_pkg.sv
// Shared frame geometry, counter widths and FSM encoding for the binarizer and blob counter.
package blob_pkg;

  localparam int IMG_COL = 800;
  localparam int IMG_ROW = 600;
  localparam int LUMA_W  = 10;
  localparam int CNT_W   = 19;
  localparam int POS_W   = 10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREFILL,
    S_STREAM,
    S_FLUSH,
    S_DONE
  } state_t;

endpackage

// File: rtl/blob_line_buffer.sv
// One-bit circular delay line: delayed is the bit written DEPTH shifts ago.
module blob_line_buffer
  import blob_pkg::*;
#(
  parameter int DEPTH = IMG_COL
) (
  input  logic clk,
  input  logic rst_n,
  input  logic shift_en,
  input  logic data,
  output logic delayed
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

  logic [DEPTH-1:0] cells;
  logic [PTR_W-1:0] ptr;

  assign delayed = cells[ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cells <= '0;
      ptr   <= '0;
    end else if (shift_en) begin
      cells[ptr] <= data;
      ptr        <= (ptr == PTR_LAST) ? '0 : ptr + 1'b1;
    end
  end

endmodule

// File: rtl/blob_binarize.sv
// RGB-to-luma threshold with a 3x3 majority filter, emitting one filtered bit per clock
// for a whole frame once the first row plus two pixels have been prefetched.
module blob_binarize
  import blob_pkg::*;
#(
  parameter int IMG_COL = blob_pkg::IMG_COL,
  parameter int IMG_ROW = blob_pkg::IMG_ROW,
  parameter int PIX_W   = LUMA_W,
  parameter int INVERT  = 0
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [PIX_W-1:0] i_thresh,
  input  logic [PIX_W-1:0] i_r,
  input  logic [PIX_W-1:0] i_g,
  input  logic [PIX_W-1:0] i_b,
  input  logic             i_pix_valid,
  output logic             o_pix_read,
  output logic             o_valid,
  output logic             o_seq,
  output logic             o_underrun,
  output logic             o_busy
);

  localparam logic [CNT_W-1:0] PIX_TOTAL    = CNT_W'(IMG_COL * IMG_ROW);
  localparam logic [CNT_W-1:0] PIX_LAST     = CNT_W'(IMG_COL * IMG_ROW - 1);
  localparam logic [CNT_W-1:0] PREFILL_LAST = CNT_W'(IMG_COL + 1);
  localparam logic [POS_W-1:0] COL_LAST     = POS_W'(IMG_COL - 1);
  localparam logic [POS_W-1:0] ROW_LAST     = POS_W'(IMG_ROW - 1);
  localparam logic             INV_BIT      = (INVERT != 0);

  state_t           state;
  logic [PIX_W-1:0] thresh;
  logic [CNT_W-1:0] in_cnt;
  logic [CNT_W-1:0] out_cnt;
  logic [POS_W-1:0] col;
  logic [POS_W-1:0] row;
  logic [2:0]       win_top;
  logic [2:0]       win_mid;
  logic [2:0]       win_bot;

  logic [PIX_W+1:0] luma_sum;
  logic [PIX_W-1:0] luma;
  logic             pix_bit;
  logic             inputs_left;
  logic             pop;
  logic             emit;
  logic             shift_en;
  logic             shift_bit;
  logic             lb1_out;
  logic             lb2_out;
  logic [2:0]       col_mask;
  logic [8:0]       hood;
  logic [3:0]       ones;
  logic             majority;

  assign luma_sum = {2'b00, i_r} + {1'b0, i_g, 1'b0} + {2'b00, i_b};
  assign luma     = luma_sum[PIX_W+1:2];
  assign pix_bit  = (luma >= thresh) ^ INV_BIT;

  assign inputs_left = (in_cnt != PIX_TOTAL);
  assign pop  = i_pix_valid && ((state == S_PREFILL) || ((state == S_STREAM) && inputs_left));
  assign emit = ((state == S_STREAM) || (state == S_FLUSH)) && (out_cnt != PIX_TOTAL);
  assign o_pix_read = pop;
  assign o_busy     = (state != S_IDLE);

  // Stream and flush shift every cycle; a missing pixel or flush padding enters as 0.
  always_comb begin
    shift_en  = 1'b0;
    shift_bit = 1'b0;
    case (state)
      S_PREFILL: begin
        shift_en  = i_pix_valid;
        shift_bit = pix_bit;
      end
      S_STREAM: begin
        shift_en  = 1'b1;
        shift_bit = pop && pix_bit;
      end
      S_FLUSH: shift_en = 1'b1;
      default: ;
    endcase
  end

  blob_line_buffer #(.DEPTH(IMG_COL)) u_line1 (
    .clk      (i_clk),
    .rst_n    (i_rst_n),
    .shift_en (shift_en),
    .data     (shift_bit),
    .delayed  (lb1_out)
  );

  blob_line_buffer #(.DEPTH(IMG_COL)) u_line2 (
    .clk      (i_clk),
    .rst_n    (i_rst_n),
    .shift_en (shift_en),
    .data     (lb1_out),
    .delayed  (lb2_out)
  );

  // Bit 0 of each window row is the newest (rightmost) column.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      win_top <= '0;
      win_mid <= '0;
      win_bot <= '0;
    end else if (shift_en) begin
      win_top <= {win_top[1:0], lb2_out};
      win_mid <= {win_mid[1:0], lb1_out};
      win_bot <= {win_bot[1:0], shift_bit};
    end
  end

  // Edge neighbours hold wrapped or stale bits, so they are forced to 0 here.
  always_comb begin
    col_mask = {(col != '0), 1'b1, (col != COL_LAST)};
    hood     = {((row == '0) ? 3'b000 : win_top & col_mask),
                win_mid & col_mask,
                ((row == ROW_LAST) ? 3'b000 : win_bot & col_mask)};
    ones = '0;
    for (int i = 0; i < 9; i++) begin
      ones = ones + {3'b000, hood[i]};
    end
  end

  assign majority = (ones >= 4'd5);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= S_IDLE;
      thresh     <= '0;
      in_cnt     <= '0;
      out_cnt    <= '0;
      col        <= '0;
      row        <= '0;
      o_valid    <= 1'b0;
      o_seq      <= 1'b0;
      o_underrun <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (i_start) begin
            thresh     <= i_thresh;
            o_underrun <= 1'b0;
            in_cnt     <= '0;
            out_cnt    <= '0;
            col        <= '0;
            row        <= '0;
            state      <= S_PREFILL;
          end
        end
        S_PREFILL: begin
          if (pop) begin
            in_cnt <= in_cnt + 1'b1;
            if (in_cnt == PREFILL_LAST) begin
              o_valid <= 1'b1;
              state   <= S_STREAM;
            end
          end
        end
        S_STREAM, S_FLUSH: begin
          if (pop) begin
            in_cnt <= in_cnt + 1'b1;
          end
          if ((state == S_STREAM) && inputs_left && !i_pix_valid) begin
            o_underrun <= 1'b1;
          end
          if (emit) begin
            o_seq   <= majority;
            out_cnt <= out_cnt + 1'b1;
            if (col == COL_LAST) begin
              col <= '0;
              row <= (row == ROW_LAST) ? '0 : row + 1'b1;
            end else begin
              col <= col + 1'b1;
            end
          end else begin
            o_seq   <= 1'b0;
            o_valid <= 1'b0;
          end
          // Long underruns can finish the output before the last pop; keep draining.
          if ((state == S_STREAM) && pop && (in_cnt == PIX_LAST)) begin
            state <= S_FLUSH;
          end else if ((state == S_FLUSH) && !emit) begin
            state <= S_DONE;
          end
        end
        S_DONE: begin
          if (!i_start) begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_blob_binarize.sv
// Directed frame-level bench on a 16x10 frame, with a second instance built with INVERT=1.
module tb_blob_binarize;

  localparam int COLS    = 16;
  localparam int ROWS    = 10;
  localparam int NPIX    = COLS * ROWS;
  localparam int PW      = 10;
  localparam int TIMEOUT = 4 * NPIX + 100;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [PW-1:0] thresh;
  logic [PW-1:0] r;
  logic [PW-1:0] g;
  logic [PW-1:0] b;
  logic          pix_valid;
  logic          pix_read, valid, seq, underrun, busy;
  logic          pix_read_inv, valid_inv, seq_inv, underrun_inv, busy_inv;

  logic [PW-1:0] img_r [NPIX];
  logic [PW-1:0] img_g [NPIX];
  logic [PW-1:0] img_b [NPIX];
  logic          out_bits [NPIX];

  int n_compared = 0;
  int n_mismatched = 0;
  int pops, valid_cycles, valid_start, c2_pop_cycle, ones, ones_inv, bad_seq, bad_pop;
  logic timed_out, aborted, busy_after, underrun_after, underrun_at_start;

  always #5 clk = ~clk;

  blob_binarize #(.IMG_COL(COLS), .IMG_ROW(ROWS), .PIX_W(PW), .INVERT(0)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_thresh(thresh),
    .i_r(r), .i_g(g), .i_b(b), .i_pix_valid(pix_valid),
    .o_pix_read(pix_read), .o_valid(valid), .o_seq(seq),
    .o_underrun(underrun), .o_busy(busy)
  );

  blob_binarize #(.IMG_COL(COLS), .IMG_ROW(ROWS), .PIX_W(PW), .INVERT(1)) dut_inv (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_thresh(thresh),
    .i_r(r), .i_g(g), .i_b(b), .i_pix_valid(pix_valid),
    .o_pix_read(pix_read_inv), .o_valid(valid_inv), .o_seq(seq_inv),
    .o_underrun(underrun_inv), .o_busy(busy_inv)
  );

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  task automatic fillFrame(input int rv, input int gv, input int bv);
    for (int i = 0; i < NPIX; i++) begin
      img_r[i] = PW'(rv);
      img_g[i] = PW'(gv);
      img_b[i] = PW'(bv);
    end
  endtask

  task automatic paintPixel(input int row, input int col, input int v);
    img_r[row*COLS + col] = PW'(v);
    img_g[row*COLS + col] = PW'(v);
    img_b[row*COLS + col] = PW'(v);
  endtask

  // Runs one frame as FIFO + blob-counter model; abort_at >= 0 pulls reset while that output is shown.
  task automatic applyStimulus(input logic [PW-1:0] th, input int drop_at, input int drop_len,
                               input int abort_at);
    int  head, t, n;
    bit  seen, finished;
    pops = 0; valid_cycles = 0; valid_start = -1; c2_pop_cycle = -1;
    ones = 0; ones_inv = 0; bad_seq = 0; bad_pop = 0;
    aborted = 1'b0; busy_after = 1'b0; underrun_after = 1'b0;
    for (int i = 0; i < NPIX; i++) out_bits[i] = 1'b0;
    @(negedge clk);
    thresh = th; start = 1'b1; pix_valid = 1'b0;
    @(negedge clk);
    start = 1'b0;
    underrun_at_start = underrun;
    head = 0; t = 0; seen = 1'b0; finished = 1'b0;
    while (!finished && t < TIMEOUT) begin
      n = -1;
      if (valid) begin
        if (!seen) begin
          seen = 1'b1;
          valid_start = t;
        end
        valid_cycles++;
        n = t - valid_start - 1;
        if (n >= 0 && n < NPIX) begin
          out_bits[n] = seq;
          ones += int'(seq);
          ones_inv += int'(seq_inv);
        end
      end else begin
        if (seq) bad_seq++;
        if (seen) finished = 1'b1;
      end
      if (!valid_inv && seq_inv) bad_seq++;
      if (!finished) begin
        if (abort_at >= 0 && n == abort_at) begin
          rst_n = 1'b0;
          aborted = 1'b1;
          finished = 1'b1;
        end else begin
          pix_valid = (head < NPIX) &&
                      !(seen && t >= valid_start + drop_at && t < valid_start + drop_at + drop_len);
          r = (head < NPIX) ? img_r[head] : '0;
          g = (head < NPIX) ? img_g[head] : '0;
          b = (head < NPIX) ? img_b[head] : '0;
          #1;
          if (pix_read && !pix_valid) bad_pop++;
          if (pix_read) begin
            pops++;
            head++;
            if (pops == COLS + 2) c2_pop_cycle = t;
          end
          @(negedge clk);
          t++;
        end
      end
    end
    timed_out = !finished;
    if (!aborted) begin
      repeat (3) @(negedge clk);
      busy_after = busy;
      underrun_after = underrun;
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; thresh = '0;
    r = '0; g = '0; b = '0; pix_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    pix_valid = 1'b1;
    #1;
    checkOutput("rst_valid", valid, 0);
    checkOutput("rst_seq", seq, 0);
    checkOutput("rst_pix_read", pix_read, 0);
    checkOutput("rst_underrun", underrun, 0);
    checkOutput("rst_busy", busy, 0);

    $display("[TB] all-black frame");
    fillFrame(0, 0, 0);
    applyStimulus(10'd512, 0, 0, -1);
    checkOutput("black_timeout", timed_out, 0);
    checkOutput("black_ones", ones, 0);
    checkOutput("black_valid_cycles", valid_cycles, NPIX + 1);
    checkOutput("black_valid_start", valid_start, c2_pop_cycle + 1);
    checkOutput("black_pops", pops, NPIX);
    checkOutput("black_underrun", underrun_after, 0);
    checkOutput("black_seq_outside", bad_seq, 0);
    checkOutput("black_busy_after", busy_after, 0);

    $display("[TB] all-white frame");
    fillFrame(1023, 1023, 1023);
    applyStimulus(10'd512, 0, 0, -1);
    checkOutput("white_ones", ones, NPIX - 4);
    checkOutput("white_bit_0_0", out_bits[0], 0);
    checkOutput("white_bit_0_1", out_bits[1], 1);
    checkOutput("white_bit_0_15", out_bits[15], 0);
    checkOutput("white_bit_1_0", out_bits[16], 1);
    checkOutput("white_bit_9_0", out_bits[144], 0);
    checkOutput("white_bit_9_15", out_bits[159], 0);
    checkOutput("white_inv_ones", ones_inv, 0);

    $display("[TB] single white pixel");
    fillFrame(0, 0, 0);
    paintPixel(5, 7, 1023);
    applyStimulus(10'd512, 0, 0, -1);
    checkOutput("dot_ones", ones, 0);
    checkOutput("dot_inv_ones", ones_inv, NPIX - 4);

    $display("[TB] 3x3 white block");
    fillFrame(0, 0, 0);
    for (int rr = 3; rr <= 5; rr++)
      for (int cc = 3; cc <= 5; cc++) paintPixel(rr, cc, 1023);
    applyStimulus(10'd512, 0, 0, -1);
    checkOutput("block_ones", ones, 5);
    checkOutput("block_bit_4_4", out_bits[68], 1);
    checkOutput("block_bit_3_4", out_bits[52], 1);
    checkOutput("block_bit_5_4", out_bits[84], 1);
    checkOutput("block_bit_4_3", out_bits[67], 1);
    checkOutput("block_bit_4_5", out_bits[69], 1);
    checkOutput("block_bit_3_3", out_bits[51], 0);
    checkOutput("block_bit_5_5", out_bits[85], 0);

    $display("[TB] threshold boundary");
    fillFrame(0, 256, 512);
    applyStimulus(10'd256, 0, 0, -1);
    checkOutput("thr_eq_ones", ones, NPIX - 4);
    checkOutput("thr_eq_inv_ones", ones_inv, 0);
    fillFrame(0, 255, 510);
    applyStimulus(10'd256, 0, 0, -1);
    checkOutput("thr_below_ones", ones, 0);
    checkOutput("thr_below_inv_ones", ones_inv, NPIX - 4);
    fillFrame(1, 256, 510);
    applyStimulus(10'd256, 0, 0, -1);
    checkOutput("thr_trunc_ones", ones, 0);

    $display("[TB] FIFO dropout mid-stream");
    fillFrame(1023, 1023, 1023);
    applyStimulus(10'd512, 20, 10, -1);
    checkOutput("drop_timeout", timed_out, 0);
    checkOutput("drop_valid_cycles", valid_cycles, NPIX + 1);
    checkOutput("drop_valid_start", valid_start, c2_pop_cycle + 1);
    checkOutput("drop_pops", pops, NPIX);
    checkOutput("drop_underrun_sticky", underrun_after, 1);
    checkOutput("drop_pop_without_valid", bad_pop, 0);

    $display("[TB] reset mid-frame");
    applyStimulus(10'd512, 0, 0, 80);
    checkOutput("abort_underrun_cleared", underrun_at_start, 0);
    checkOutput("abort_reached", aborted, 1);
    #1;
    checkOutput("abort_valid", valid, 0);
    checkOutput("abort_seq", seq, 0);
    checkOutput("abort_pix_read", pix_read, 0);
    checkOutput("abort_underrun", underrun, 0);
    checkOutput("abort_busy", busy, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(10'd512, 0, 0, -1);
    checkOutput("rerun_ones", ones, NPIX - 4);
    checkOutput("rerun_bit_0_0", out_bits[0], 0);
    checkOutput("rerun_bit_0_1", out_bits[1], 1);
    checkOutput("rerun_valid_cycles", valid_cycles, NPIX + 1);
    checkOutput("rerun_pops", pops, NPIX);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
